// File: rtl/udc_pkg.sv
// Shared state encodings and direction constants for the up/down sweep controller.
package udc_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_UP       = 3'd1;
  localparam logic [2:0] S_DWELL_HI = 3'd2;
  localparam logic [2:0] S_DOWN     = 3'd3;
  localparam logic [2:0] S_DWELL_LO = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    UP       = S_UP,
    DWELL_HI = S_DWELL_HI,
    DOWN     = S_DOWN,
    DWELL_LO = S_DWELL_LO,
    DONE     = S_DONE
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == UP) || (s == DWELL_HI) || (s == DOWN) || (s == DWELL_LO);
  endfunction

endpackage

// File: rtl/updown_core.sv
// N-bit up/down counter with synchronous load; direction and enable come from the controller.
module updown_core
  import udc_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         m,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (m == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer driving an up/down counter between latched bounds.
// Optional freeze input enabled by defining UDC_PAUSE_EN.
module updown_sweep_ctrl
  import udc_pkg::*;
#(
  parameter int N  = 3,
  parameter int SW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic [SW-1:0] sweeps,
  input  logic [DW-1:0] dwell,
`ifdef UDC_PAUSE_EN
  input  logic          pause,
`endif
  output logic [N-1:0]  counter,
  output logic          m,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweep_cnt
);

  state_t        state, state_nx;
  logic [N-1:0]  lo_r, hi_r;
  logic [SW-1:0] sweeps_r, sweep_cnt_nx, sweep_inc;
  logic [DW-1:0] dwell_r, timer, timer_nx;
  logic          m_nx, err_nx, accept, core_en, core_load, frozen;

`ifdef UDC_PAUSE_EN
  assign frozen = pause && is_busy(state);
`else
  assign frozen = 1'b0;
`endif

  assign busy = is_busy(state);
  assign done = (state == DONE);

  updown_core #(.N(N)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (core_en),
    .m        (m),
    .load     (core_load),
    .load_val (lo),
    .count    (counter)
  );

  // Bound checks look one step ahead so the transition lands on the edge that writes the bound.
  always_comb begin
    state_nx     = state;
    m_nx         = m;
    timer_nx     = timer;
    sweep_cnt_nx = sweep_cnt;
    err_nx       = 1'b0;
    accept       = 1'b0;
    core_en      = 1'b0;
    core_load    = 1'b0;
    sweep_inc    = sweep_cnt + 1'b1;

    if (busy && abort) begin
      state_nx = IDLE;
    end else if (!frozen) begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (lo < hi) begin
              accept       = 1'b1;
              core_load    = 1'b1;
              m_nx         = DIR_UP;
              sweep_cnt_nx = '0;
              state_nx     = UP;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        UP: begin
          core_en = 1'b1;
          if (counter == hi_r - 1'b1) begin
            if (dwell_r != '0) begin
              state_nx = DWELL_HI;
              timer_nx = dwell_r;
            end else begin
              state_nx = DOWN;
              m_nx     = DIR_DN;
            end
          end
        end
        DWELL_HI: begin
          timer_nx = timer - 1'b1;
          if (timer == DW'(1)) begin
            state_nx = DOWN;
            m_nx     = DIR_DN;
          end
        end
        DOWN: begin
          core_en = 1'b1;
          if (counter == lo_r + 1'b1) begin
            sweep_cnt_nx = sweep_inc;
            if (sweeps_r != '0 && sweep_inc == sweeps_r) begin
              state_nx = DONE;
            end else if (dwell_r != '0) begin
              state_nx = DWELL_LO;
              timer_nx = dwell_r;
            end else begin
              state_nx = UP;
              m_nx     = DIR_UP;
            end
          end
        end
        DWELL_LO: begin
          timer_nx = timer - 1'b1;
          if (timer == DW'(1)) begin
            state_nx = UP;
            m_nx     = DIR_UP;
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      m         <= DIR_DN;
      timer     <= '0;
      sweep_cnt <= '0;
      err       <= 1'b0;
      lo_r      <= '0;
      hi_r      <= '0;
      sweeps_r  <= '0;
      dwell_r   <= '0;
    end else begin
      state     <= state_nx;
      m         <= m_nx;
      timer     <= timer_nx;
      sweep_cnt <= sweep_cnt_nx;
      err       <= err_nx;
      if (accept) begin
        lo_r     <= lo;
        hi_r     <= hi;
        sweeps_r <= sweeps;
        dwell_r  <= dwell;
      end
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed self-checking bench for updown_sweep_ctrl (N=3); pause checks build with UDC_PAUSE_EN.
module tb_updown_sweep_ctrl;

  localparam int N  = 3;
  localparam int SW = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  lo = '0;
  logic [N-1:0]  hi = '0;
  logic [SW-1:0] sweeps = '0;
  logic [DW-1:0] dwell = '0;
`ifdef UDC_PAUSE_EN
  logic          pause = 1'b0;
`endif
  logic [N-1:0]  counter;
  logic          m, busy, done, err;
  logic [SW-1:0] sweep_cnt;

  int checks = 0;
  int failures = 0;

  updown_sweep_ctrl #(.N(N), .SW(SW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .lo        (lo),
    .hi        (hi),
    .sweeps    (sweeps),
    .dwell     (dwell),
`ifdef UDC_PAUSE_EN
    .pause     (pause),
`endif
    .counter   (counter),
    .m         (m),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_cnt (sweep_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] l, input logic [N-1:0] h,
                               input logic [SW-1:0] s, input logic [DW-1:0] d);
    lo = l; hi = h; sweeps = s; dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int t1_cnt [6] = '{2, 3, 4, 3, 2, 1};
  int t1_m   [6] = '{1, 1, 0, 0, 0, 0};
  int t2_cnt [34] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0,
                      1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0};

  initial begin
    // reset
    tick(); tick();
    checkOutput("rst_counter", int'(counter), 0);
    checkOutput("rst_m", int'(m), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_sweep_cnt", int'(sweep_cnt), 0);
    reset_n = 1'b1;
    tick();

    // single sweep 1..4..1, no dwell
    applyStimulus(3'd1, 3'd4, 4'd1, 4'd0);
    checkOutput("t1_load", int'(counter), 1);
    checkOutput("t1_busy0", int'(busy), 1);
    checkOutput("t1_m0", int'(m), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t1_cnt%0d", i), int'(counter), t1_cnt[i]);
      checkOutput($sformatf("t1_m%0d", i), int'(m), t1_m[i]);
      checkOutput($sformatf("t1_done%0d", i), int'(done), (i == 5) ? 1 : 0);
    end
    checkOutput("t1_busy_done", int'(busy), 0);
    checkOutput("t1_sweep_cnt", int'(sweep_cnt), 1);
    tick();
    checkOutput("t1_done_clr", int'(done), 0);
    checkOutput("t1_hold_lo", int'(counter), 1);

    // two sweeps 0..7 with dwell 2
    applyStimulus(3'd0, 3'd7, 4'd2, 4'd2);
    checkOutput("t2_load", int'(counter), 0);
    for (int i = 0; i < 34; i++) begin
      tick();
      checkOutput($sformatf("t2_cnt%0d", i), int'(counter), t2_cnt[i]);
      checkOutput($sformatf("t2_busy%0d", i), int'(busy), (i == 33) ? 0 : 1);
      checkOutput($sformatf("t2_done%0d", i), int'(done), (i == 33) ? 1 : 0);
      if (i == 16) checkOutput("t2_sweep_mid", int'(sweep_cnt), 1);
    end
    checkOutput("t2_sweep_end", int'(sweep_cnt), 2);
    tick();

    // rejected starts
    applyStimulus(3'd5, 3'd5, 4'd1, 4'd0);
    checkOutput("t3a_err", int'(err), 1);
    checkOutput("t3a_busy", int'(busy), 0);
    checkOutput("t3a_counter", int'(counter), 0);
    tick();
    checkOutput("t3a_err_clr", int'(err), 0);
    applyStimulus(3'd6, 3'd2, 4'd1, 4'd0);
    checkOutput("t3b_err", int'(err), 1);
    checkOutput("t3b_busy", int'(busy), 0);
    checkOutput("t3b_counter", int'(counter), 0);
    tick();
    checkOutput("t3b_err_clr", int'(err), 0);

    // continuous 2..3 sweep, sweep_cnt wraps, then abort in DOWN
    applyStimulus(3'd2, 3'd3, 4'd0, 4'd0);
    checkOutput("t4_load", int'(counter), 2);
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput($sformatf("t4_cnt%0d", i), int'(counter), (i % 2 == 0) ? 3 : 2);
      checkOutput($sformatf("t4_sw%0d", i), int'(sweep_cnt), ((i + 1) / 2) % 16);
    end
    tick();
    checkOutput("t4_down_cnt", int'(counter), 3);
    checkOutput("t4_down_m", int'(m), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_abort_busy", int'(busy), 0);
    checkOutput("t4_abort_done", int'(done), 0);
    checkOutput("t4_abort_cnt", int'(counter), 3);
    tick();
    checkOutput("t4_idle_cnt", int'(counter), 3);
    checkOutput("t4_idle_done", int'(done), 0);
    checkOutput("t4_idle_busy", int'(busy), 0);

    // start with abort in IDLE, then start during busy
    lo = 3'd1; hi = 3'd4; sweeps = 4'd1; dwell = 4'd0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("t5_sa_busy", int'(busy), 0);
    checkOutput("t5_sa_cnt", int'(counter), 3);
    checkOutput("t5_sa_err", int'(err), 0);
    applyStimulus(3'd1, 3'd4, 4'd1, 4'd0);
    tick();
    checkOutput("t5_run_cnt", int'(counter), 2);
    lo = 3'd0; hi = 3'd7; sweeps = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t5_ign_cnt", int'(counter), 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t5_cnt%0d", i), int'(counter), t1_cnt[i + 2]);
    end
    checkOutput("t5_done", int'(done), 1);
    checkOutput("t5_sweep_cnt", int'(sweep_cnt), 1);
    tick();

    // asynchronous reset mid-UP
    applyStimulus(3'd0, 3'd7, 4'd1, 4'd0);
    tick(); tick();
    checkOutput("t6_pre_cnt", int'(counter), 2);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_cnt", int'(counter), 0);
    checkOutput("t6_rst_m", int'(m), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_sweep", int'(sweep_cnt), 0);
    #2;
    reset_n = 1'b1;
    tick();
    checkOutput("t6_after_busy", int'(busy), 0);

`ifdef UDC_PAUSE_EN
    applyStimulus(3'd1, 3'd6, 4'd1, 4'd0);
    tick();
    checkOutput("tp_pre_cnt", int'(counter), 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("tp_hold%0d", i), int'(counter), 2);
    end
    pause = 1'b0;
    tick();
    checkOutput("tp_resume", int'(counter), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("tp_abort_busy", int'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
